// File: rtl/io_debouncer.sv
// Per-channel input debouncer: two-flop synchronizer, stability counter and
// registered rise/fall pulses. Each channel is an independent lane instance.
module io_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic cu_clk,
  input  logic btn_reset,
  input  logic raw_in,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    sync_d   = {sync_q[0], raw_in};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    // Any agreement with the current level restarts the stability window.
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d    = '0;
      stable_d = sync_q[1];
      rise_d   = sync_q[1];
      fall_d   = ~sync_q[1];
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge cu_clk) begin
    if (btn_reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
endmodule

module io_debouncer #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic         cu_clk,
  input  logic         btn_reset,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] stable,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         any_rise
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    io_debouncer_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .cu_clk   (cu_clk),
      .btn_reset(btn_reset),
      .raw_in   (raw_in[i]),
      .stable   (stable[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  // rise is already registered, so the OR is a clean one-cycle strobe.
  assign any_rise = |rise;
endmodule

// File: tb/tb_io_debouncer.sv
// Directed and model-checked bench for io_debouncer (N=4, DEBOUNCE_CYCLES=4),
// plus a small DEBOUNCE_CYCLES=1 instance.
module tb_io_debouncer;
  logic       cu_clk = 1'b0;
  logic       btn_reset;
  logic [3:0] raw_in;
  logic [3:0] stable, rise, fall;
  logic       any_rise;
  logic [1:0] raw1, stable1, rise1, fall1;
  logic       any_rise1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 cu_clk = ~cu_clk;

  io_debouncer #(.N(4), .DEBOUNCE_CYCLES(4)) dut (
    .cu_clk(cu_clk), .btn_reset(btn_reset), .raw_in(raw_in),
    .stable(stable), .rise(rise), .fall(fall), .any_rise(any_rise)
  );

  io_debouncer #(.N(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .cu_clk(cu_clk), .btn_reset(btn_reset), .raw_in(raw1),
    .stable(stable1), .rise(rise1), .fall(fall1), .any_rise(any_rise1)
  );

  logic [3:0][2:0] dut_cnt;
  assign dut_cnt[0] = dut.g_lane[0].u_lane.cnt_q;
  assign dut_cnt[1] = dut.g_lane[1].u_lane.cnt_q;
  assign dut_cnt[2] = dut.g_lane[2].u_lane.cnt_q;
  assign dut_cnt[3] = dut.g_lane[3].u_lane.cnt_q;

  // Reference model of the N=4, D=4 instance for the random phase.
  logic [3:0] m_s1, m_s2, m_st, m_r, m_f;
  int         m_cnt [4];

  always @(posedge cu_clk) begin
    if (btn_reset) begin
      m_s1 <= '0; m_s2 <= '0; m_st <= '0; m_r <= '0; m_f <= '0;
      for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
    end else begin
      m_s1 <= raw_in;
      m_s2 <= m_s1;
      for (int i = 0; i < 4; i++) begin
        m_r[i] <= 1'b0;
        m_f[i] <= 1'b0;
        if (m_s2[i] == m_st[i]) m_cnt[i] <= 0;
        else if (m_cnt[i] == 3) begin
          m_cnt[i] <= 0;
          m_st[i]  <= m_s2[i];
          m_r[i]   <= m_s2[i];
          m_f[i]   <= ~m_s2[i];
        end else m_cnt[i] <= m_cnt[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cu_clk);
    #1;
  endtask

  // Hold for n-1 edges with no change, then expect the transition and pulses,
  // then expect the pulses to drop one edge later.
  task automatic wait_chk(input string tag, input int n, input logic [3:0] st0,
                          input logic [3:0] st1, input logic [3:0] r, input logic [3:0] f);
    for (int k = 1; k < n; k++) begin
      tick();
      chk({tag, " hold stable"}, 32'(stable), 32'(st0));
      chk({tag, " hold pulses"}, 32'({rise, fall, any_rise}), 32'(0));
    end
    tick();
    chk({tag, " stable"}, 32'(stable), 32'(st1));
    chk({tag, " rise"}, 32'(rise), 32'(r));
    chk({tag, " fall"}, 32'(fall), 32'(f));
    chk({tag, " any_rise"}, 32'(any_rise), 32'(|r));
    tick();
    chk({tag, " pulse drop"}, 32'({rise, fall, any_rise}), 32'(0));
    chk({tag, " stable kept"}, 32'(stable), 32'(st1));
  endtask

  initial begin
    btn_reset = 1'b1;
    raw_in    = 4'b0000;
    raw1      = 2'b00;
    tick(); tick();
    chk("reset stable", 32'(stable), 0);
    chk("reset pulses", 32'({rise, fall, any_rise}), 0);
    btn_reset = 1'b0;

    // Clean press on channel 0
    raw_in = 4'b0001;
    wait_chk("press", 6, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    // Release, then bounce 1,0,1,0 before holding 1
    raw_in = 4'b0000;
    wait_chk("release", 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      raw_in[0] = (k % 2 == 0);
      tick();
      chk("bounce stable", 32'(stable), 0);
      chk("bounce pulses", 32'({rise, fall}), 0);
    end
    raw_in = 4'b0001;
    wait_chk("bounce settle", 6, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    // Glitch of 3 cycles on channel 2 must be rejected
    raw_in = 4'b0101;
    tick(); tick(); tick();
    raw_in = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("glitch stable", 32'(stable), 32'(4'b0001));
      chk("glitch pulses", 32'({rise, fall, any_rise}), 0);
    end

    // Multi-channel simultaneous rise and fall
    raw_in = 4'b0011;
    wait_chk("to 0011", 6, 4'b0001, 4'b0011, 4'b0010, 4'b0000);
    raw_in = 4'b1100;
    wait_chk("swap", 6, 4'b0011, 4'b1100, 4'b1100, 4'b0011);

    // Reset at count 2 discards progress, input held through release
    raw_in = 4'b1111;
    tick(); tick(); tick(); tick();
    chk("pre-reset cnt", 32'(dut_cnt[0]), 2);
    btn_reset = 1'b1;
    tick();
    chk("mid reset stable", 32'(stable), 0);
    chk("mid reset pulses", 32'({rise, fall, any_rise}), 0);
    btn_reset = 1'b0;
    wait_chk("post reset", 6, 4'b0000, 4'b1111, 4'b1111, 4'b0000);

    // DEBOUNCE_CYCLES = 1 instance: stable follows sync one cycle later
    btn_reset = 1'b1;
    raw_in    = 4'b0000;
    tick();
    btn_reset = 1'b0;
    raw1      = 2'b01;
    tick(); chk("d1 e1", 32'(stable1), 0);
    tick(); chk("d1 e2", 32'(stable1), 0);
    tick();
    chk("d1 stable", 32'(stable1), 1);
    chk("d1 rise", 32'({rise1, any_rise1}), 32'(3'b011));
    tick(); chk("d1 rise drop", 32'(rise1), 0);
    raw1 = 2'b10;
    tick(); tick(); tick();
    chk("d1 swap stable", 32'(stable1), 2);
    chk("d1 swap pulses", 32'({rise1, fall1}), 32'(4'b1001));

    // Random stimulus against the reference model
    btn_reset = 1'b1;
    tick();
    btn_reset = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(3) == 0) raw_in = raw_in ^ 4'($urandom_range(15));
      tick();
      chk("rnd stable", 32'(stable), 32'(m_st));
      chk("rnd rise", 32'(rise), 32'(m_r));
      chk("rnd fall", 32'(fall), 32'(m_f));
      chk("rnd any_rise", 32'(any_rise), 32'(|m_r));
      for (int i = 0; i < 4; i++) chk("rnd cnt", 32'(dut_cnt[i]), 32'(m_cnt[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
